// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings, ALU op and FSM state types for the multi-cycle MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_ALUWB,
        ST_MEMADDR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    // Wrapping two's-complement ALU; slt compares signed
    function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - register file: two async read ports, one sync write port, async clear, r0 fixed at zero
module mips_regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear everything on reset; writes to r0 are dropped so it always holds zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_cpu.sv
// rtl/mips_multicycle_cpu.sv - multi-cycle MIPS-subset core on one stallable memory port; MIPS_MC_EXT_EN adds bne/andi/ori
module mips_multicycle_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          REG_ADDR_W      = 5,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        illegal
);

    state_t      state, state_next;
    logic [31:0] pc_q, ir, a_q, b_q, alu_out, mdr, br_target;
    logic        illegal_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic        unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign imm          = ir[15:0];
    assign imm_sext     = {{16{imm[15]}}, imm};
    assign unused_shamt = ^ir[10:6];

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_logic_imm, legal;

    // Instruction class decode from the latched IR
    always_comb begin
        is_rtype = (opcode == OP_RTYPE) &&
                   ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT));
        is_addi  = (opcode == OP_ADDI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
`ifdef MIPS_MC_EXT_EN
        is_bne       = (opcode == OP_BNE);
        is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
`else
        is_bne       = 1'b0;
        is_logic_imm = 1'b0;
`endif
        legal = is_rtype || is_addi || is_lw || is_sw || is_beq || is_bne || is_j || is_logic_imm;
    end

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_result;

    // ALU operation and second operand: register B for R-type, immediate otherwise
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = b_q;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (opcode == OP_ADDI) begin
            alu_b = imm_sext;
`ifdef MIPS_MC_EXT_EN
        end else if (opcode == OP_ANDI) begin
            alu_op = ALU_AND;
            alu_b  = {16'h0000, imm};
        end else if (opcode == OP_ORI) begin
            alu_op = ALU_OR;
            alu_b  = {16'h0000, imm};
`endif
        end
    end

    assign alu_result = alu_calc(alu_op, a_q, alu_b);

    logic [31:0]           rd1, rd2, rf_wd;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic                  rf_we, br_taken;

    assign rf_we    = (state == ST_ALUWB) || (state == ST_MEMWB);
    assign rf_wa    = ((state == ST_ALUWB) && (opcode == OP_RTYPE)) ? rd[REG_ADDR_W-1:0]
                                                                     : rt[REG_ADDR_W-1:0];
    assign rf_wd    = (state == ST_ALUWB) ? alu_out : mdr;
    assign br_taken = is_bne ? (a_q != b_q) : (a_q == b_q);

    mips_regfile #(
        .ADDR_W(REG_ADDR_W),
        .DATA_W(32)
    ) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (rs[REG_ADDR_W-1:0]),
        .rd1  (rd1),
        .ra2  (rt[REG_ADDR_W-1:0]),
        .rd2  (rd2),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: memory states hold until mem_ready; HALT is terminal
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:   if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_rtype || is_addi || is_logic_imm) state_next = ST_EXEC;
                else if (is_lw || is_sw)                  state_next = ST_MEMADDR;
                else if (is_beq || is_bne)                state_next = ST_BRANCH;
                else if (is_j)                            state_next = ST_JUMP;
                else                                      state_next = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
            end
            ST_EXEC:    state_next = ST_ALUWB;
            ST_ALUWB:   state_next = ST_FETCH;
            ST_MEMADDR: state_next = is_lw ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   if (mem_ready) state_next = ST_MEMWB;
            ST_MEMWB:   state_next = ST_FETCH;
            ST_MEMWR:   if (mem_ready) state_next = ST_FETCH;
            ST_BRANCH:  state_next = ST_FETCH;
            ST_JUMP:    state_next = ST_FETCH;
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_FETCH;
        endcase
    end

    // Datapath registers: PC, IR, operand latches, ALUOut, MDR, branch target, sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            br_target <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir   <= mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_DECODE: begin
                    a_q       <= rd1;
                    b_q       <= rd2;
                    br_target <= pc_q + {imm_sext[29:0], 2'b00};
                    if (!legal) illegal_q <= 1'b1;
                end
                ST_EXEC:    alu_out <= alu_result;
                ST_MEMADDR: alu_out <= a_q + imm_sext;
                ST_MEMRD:   if (mem_ready) mdr <= mem_rdata;
                ST_BRANCH:  if (br_taken) pc_q <= br_target;
                ST_JUMP:    pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Bus outputs decode from registered state; rst_n gating drops a pending request the instant reset asserts
    always_comb begin
        mem_req   = rst_n && ((state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR));
        mem_we    = (state == ST_MEMWR);
        mem_addr  = (state == ST_FETCH) ? {pc_q[31:2], 2'b00} : {alu_out[31:2], 2'b00};
        mem_wdata = b_q;
        retire    = (state == ST_ALUWB) || (state == ST_MEMWB) || (state == ST_BRANCH) ||
                    (state == ST_JUMP) || ((state == ST_MEMWR) && mem_ready) ||
                    ((state == ST_DECODE) && !legal && !HALT_ON_ILLEGAL);
        halted    = (state == ST_HALT);
    end

    assign pc      = pc_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// tb/tb_mips_multicycle_cpu.sv - directed and randomized checks of mips_multicycle_cpu against an instruction-level model
module tb_mips_multicycle_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic        mem_req2, mem_we2, retire2, halted2, illegal2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;

    logic [31:0] mem  [256];
    logic [31:0] img  [256];
    logic [31:0] mem2 [256];
    logic        load_req  = 1'b0;
    int          fixed_lat = 0;
    bit          rand_mode = 1'b0;
    int          cnt       = 0;
    int          rlat      = 0;
    int          n_assert  = 0;
    int          n_fail    = 0;

    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_ready  = mem_req && (cnt == (rand_mode ? rlat : fixed_lat));
    assign mem_rdata2 = mem2[mem_addr2[9:2]];

    mips_multicycle_cpu dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .halted(halted), .illegal(illegal)
    );

    mips_multicycle_cpu #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(1'b1), .pc(pc2),
        .retire(retire2), .halted(halted2), .illegal(illegal2)
    );

    // Memory model: image load, store commit, per-transaction wait-state counter
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (mem_req && !mem_ready) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            if (mem_req) rlat <= $urandom_range(0, 2);
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'hDEADBEEF;
    endtask

    task automatic load_and_reset();
        rst_n    = 1'b0;
        load_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        load_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_retires(input string tag, input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = 2000;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (retire) seen++;
            budget--;
        end
        check(tag, 32'(seen), 32'(n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] rpat;
        logic [31:0] model [8];
        logic [31:0] opa, opb, res;
        logic [15:0] imm;
        int          waits, budget, kind, d, s, t;
        bit          stable, any_req, any_ret;

        for (int i = 0; i < 256; i++) mem2[i] = 32'hDEADBEEF;
        mem2[0] = 32'hFC00_0000;
        mem2[1] = i_ins(6'h08, 0, 1, 16'd9);
        mem2[2] = i_ins(6'h04, 0, 0, 16'hFFFF);

        // Reset state
        #12;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_pc", pc, 32'h0);

        // addi/addi/add with zero-wait memory; retire timing
        clear_img();
        img[0] = i_ins(6'h08, 0, 1, 16'd5);
        img[1] = i_ins(6'h08, 0, 2, 16'd7);
        img[2] = r_ins(6'h20, 3, 1, 2);
        img[3] = i_ins(6'h2B, 0, 3, 16'd8);
        img[4] = i_ins(6'h23, 0, 4, 16'd8);
        img[5] = i_ins(6'h04, 0, 0, 16'hFFFF);
        fixed_lat = 0;
        rand_mode = 1'b0;
        load_and_reset();
        rpat = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            rpat[k-1] = retire;
            if (k == 2) begin
                check("nop_ill_retire", 32'(retire2), 1);
                check("nop_ill_pc", pc2, 32'h4);
            end
            if (k == 3) check("nop_ill_sticky", 32'(illegal2), 1);
        end
        check("retire_cycles", 32'(rpat), 32'h888);
        @(posedge clk);
        #1;
        check("add_r3", dut.u_regfile.regs[3], 32'd12);

        // sw then lw with three wait states per access
        fixed_lat = 3;
        budget    = 0;
        @(negedge clk);
        while (!(mem_req && mem_we) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("sw_req_seen", 32'(mem_req && mem_we), 1);
        waits  = 0;
        stable = 1'b1;
        while (!mem_ready && waits < 20) begin
            if (mem_addr !== 32'd8 || mem_wdata !== 32'd12 || mem_we !== 1'b1 || mem_req !== 1'b1) stable = 1'b0;
            waits++;
            @(negedge clk);
        end
        check("sw_stable", 32'(stable), 1);
        check("sw_waits", 32'(waits), 3);
        check("sw_addr", mem_addr, 32'd8);
        check("sw_wdata", mem_wdata, 32'd12);
        check("sw_retire", 32'(retire), 1);
        run_retires("lw_retire", 1);
        check("mem_word2", mem[2], 32'd12);
        check("lw_r4", dut.u_regfile.regs[4], 32'd12);

        // j, write to $0, beq not taken and taken
        clear_img();
        img[0]  = {6'h02, 26'h40};
        img[64] = i_ins(6'h08, 0, 1, 16'd3);
        img[65] = i_ins(6'h08, 0, 2, 16'd4);
        img[66] = r_ins(6'h20, 0, 1, 2);
        img[67] = i_ins(6'h04, 1, 2, 16'd3);
        img[68] = i_ins(6'h04, 1, 1, 16'hFFFF);
        fixed_lat = 0;
        load_and_reset();
        run_retires("j_retire", 1);
        check("j_pc", pc, 32'h100);
        run_retires("r0_retire", 3);
        check("r0_zero", dut.u_regfile.regs[0], 32'h0);
        run_retires("bne_path_retire", 1);
        check("beq_not_taken_pc", pc, 32'h110);
        run_retires("beq_taken_retire", 1);
        check("beq_taken_pc", pc, 32'h110);
        run_retires("beq_taken_retire2", 1);
        check("beq_taken_pc2", pc, 32'h110);

        // Illegal opcode halts
        clear_img();
        img[0] = i_ins(6'h08, 0, 1, 16'd1);
        img[1] = 32'hFC00_0000;
        load_and_reset();
        run_retires("pre_ill_retire", 1);
        @(negedge clk);
        @(negedge clk);
        check("decode_halted", 32'(halted), 0);
        check("decode_illegal", 32'(illegal), 0);
        @(negedge clk);
        check("halt_halted", 32'(halted), 1);
        check("halt_illegal", 32'(illegal), 1);
        any_req = 1'b0;
        any_ret = 1'b0;
        for (int k = 0; k < 10; k++) begin
            any_req |= mem_req;
            any_ret |= retire;
            @(negedge clk);
        end
        check("halt_no_req", 32'(any_req), 0);
        check("halt_no_retire", 32'(any_ret), 0);
        check("halt_pc", pc, 32'h8);

        // Reset during a stalled store
        clear_img();
        img[0] = i_ins(6'h08, 0, 1, 16'd77);
        img[1] = i_ins(6'h2B, 0, 1, 16'd16);
        img[2] = i_ins(6'h04, 0, 0, 16'hFFFF);
        fixed_lat = 4;
        load_and_reset();
        budget = 0;
        while (!(mem_req && mem_we) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("rsw_req_seen", 32'(mem_req && mem_we), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rsw_req_drop", 32'(mem_req), 0);
        check("rsw_pc", pc, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("rsw_mem_untouched", mem[4], 32'hDEADBEEF);

        // Random ALU program with random wait states, checked against an instruction-level model
        clear_img();
        model[0] = 32'h0;
        for (int k = 1; k < 8; k++) begin
            imm        = 16'($urandom);
            img[k-1]   = i_ins(6'h08, 0, k, imm);
            model[k]   = {{16{imm[15]}}, imm};
        end
        for (int k = 0; k < 12; k++) begin
            kind = $urandom_range(0, 5);
            d    = $urandom_range(0, 7);
            s    = $urandom_range(0, 7);
            t    = $urandom_range(0, 7);
            imm  = 16'($urandom);
            opa  = model[s];
            opb  = model[t];
            case (kind)
                0: begin img[7+k] = i_ins(6'h08, s, d, imm); res = opa + {{16{imm[15]}}, imm}; end
                1: begin img[7+k] = r_ins(6'h20, d, s, t);   res = opa + opb; end
                2: begin img[7+k] = r_ins(6'h22, d, s, t);   res = opa - opb; end
                3: begin img[7+k] = r_ins(6'h24, d, s, t);   res = opa & opb; end
                4: begin img[7+k] = r_ins(6'h25, d, s, t);   res = opa | opb; end
                default: begin img[7+k] = r_ins(6'h2A, d, s, t); res = ($signed(opa) < $signed(opb)) ? 32'd1 : 32'd0; end
            endcase
            if (d != 0) model[d] = res;
        end
        for (int k = 1; k < 8; k++) img[18+k] = i_ins(6'h2B, 0, k, 16'(512 + 4 * k));
        img[26]   = i_ins(6'h04, 0, 0, 16'hFFFF);
        rand_mode = 1'b1;
        load_and_reset();
        run_retires("rand_retire", 26);
        for (int k = 1; k < 8; k++) check($sformatf("rand_r%0d", k), mem[128+k], model[k]);

        // Illegal-as-NOP instance kept running past its illegal word
        check("nop_halted", 32'(halted2), 0);
        check("nop_illegal", 32'(illegal2), 1);
        check("nop_r1", dut_nop.u_regfile.regs[1], 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
